// File: rtl/ppu_bus_responder.sv
// Memory-side endpoint of the PPU multiplexed VRAM bus: address latch, 2 KB CIRAM
// with selectable nametable mirroring, and a req/ack forwarder for CHR accesses.
module ppu_bus_responder #(
   parameter bit CHR_WRITABLE = 1'b0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        clock_EN,
   inout  wire  [13:0] addressData_IN_OUT,
   input  logic        addressLatch_EN,
   input  logic        read_EN,
   input  logic        write_EN,
   input  logic [1:0]  mirror_SEL,
   output logic [12:0] chrAddress_OUT,
   input  logic [7:0]  chrData_IN,
   output logic [7:0]  chrData_OUT,
   output logic        chrRead_REQ,
   output logic        chrWrite_REQ,
   input  logic        chr_ACK,
   output logic        busy,
   output logic        lateAccess_FLAG
);

   typedef enum logic [2:0] {
      IDLE,
      NT_READ,
      NT_WR,
      CHR_RD,
      CHR_WR
   } state_t;

   state_t state, state_next;

   logic [13:0] bus_in;
   logic [13:0] addr_reg;
   logic [13:0] acc_addr;
   logic [7:0]  data_reg;
   logic [7:0]  wr_data;
   logic [7:0]  chr_wdata;
   logic [7:0]  ram_q;
   logic        rd_prev;
   logic        wr_prev;
   logic [1:0]  en_cnt;
   logic        late_flag;
   logic        rd_req;
   logic        wr_req;

   logic        bus_edge;
   logic        rd_start;
   logic        wr_start;
   logic        ram_re;
   logic        ram_we;
   logic [10:0] rd_idx;
   logic [10:0] wr_idx;

   logic [7:0]  ciram [0:2047];

   // A10' selection: horizontal uses A11, vertical uses A10, single-screen forces it.
   function automatic logic [10:0] nt_index(input logic [11:0] a, input logic [1:0] sel);
      logic page;
      case (sel)
         2'd0:    page = a[11];
         2'd1:    page = a[10];
         2'd2:    page = 1'b0;
         default: page = 1'b1;
      endcase
      return {page, a[9:0]};
   endfunction

   assign bus_in = addressData_IN_OUT;

   // An ALE edge both suppresses starts and freezes the strobe history, deferring the start.
   assign bus_edge = clock_EN & ~addressLatch_EN;
   assign rd_start = bus_edge & read_EN & ~rd_prev & (state == IDLE);
   assign wr_start = bus_edge & write_EN & ~wr_prev & (state == IDLE) & ~rd_start;

   assign rd_idx = nt_index(addr_reg[11:0], mirror_SEL);
   assign wr_idx = nt_index(acc_addr[11:0], mirror_SEL);
   assign ram_re = rd_start & addr_reg[13];
   assign ram_we = (state == NT_WR) & acc_addr[13];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      state_next = state;
      case (state)
         IDLE: begin
            if (rd_start) begin
               state_next = addr_reg[13] ? NT_READ : CHR_RD;
            end else if (wr_start) begin
               if (addr_reg[13])     state_next = NT_WR;
               else if (CHR_WRITABLE) state_next = CHR_WR;
            end
         end
         NT_READ, NT_WR: state_next = IDLE;
         CHR_RD, CHR_WR: if (chr_ACK) state_next = IDLE;
         default:        state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_reg  <= '0;
         acc_addr  <= '0;
         data_reg  <= '0;
         wr_data   <= '0;
         chr_wdata <= '0;
         rd_prev   <= 1'b0;
         wr_prev   <= 1'b0;
         en_cnt    <= '0;
         late_flag <= 1'b0;
         rd_req    <= 1'b0;
         wr_req    <= 1'b0;
      end else begin
         if (clock_EN && addressLatch_EN) addr_reg <= bus_in;
         if (bus_edge) begin
            rd_prev <= read_EN;
            wr_prev <= write_EN;
         end
         if (rd_start || wr_start) acc_addr <= addr_reg;
         if (wr_start) begin
            wr_data <= bus_in[7:0];
            if (CHR_WRITABLE && !addr_reg[13]) chr_wdata <= bus_in[7:0];
         end

         if (state == NT_READ)            data_reg <= ram_q;
         else if (state == CHR_RD && chr_ACK) data_reg <= chrData_IN;

         // Count clock_EN edges since the read started; the second one is the deadline.
         if (rd_start) begin
            en_cnt <= '0;
         end else if (state == CHR_RD && clock_EN) begin
            if (en_cnt == 2'd1)  late_flag <= 1'b1;
            if (en_cnt != 2'd3) en_cnt <= en_cnt + 2'd1;
         end

         rd_req <= (state_next == CHR_RD);
         wr_req <= (state_next == CHR_WR);
      end
   end

   // NOTE: the RAM array has no reset; clearing 2 KB is not a reset-time function of CIRAM.
   always_ff @(posedge clock) begin
      if (ram_we) ciram[wr_idx] <= wr_data;
      if (ram_re) ram_q <= ciram[rd_idx];
   end

   assign addressData_IN_OUT[7:0] = (read_EN && !addressLatch_EN && !reset) ? data_reg : 8'bz;

   assign chrAddress_OUT  = acc_addr[12:0];
   assign chrData_OUT     = chr_wdata;
   assign chrRead_REQ     = rd_req;
   assign chrWrite_REQ    = wr_req;
   assign busy            = (state != IDLE);
   assign lateAccess_FLAG = late_flag;

endmodule

// File: tb/tb_ppu_bus_responder.sv
// Directed bench for ppu_bus_responder: CIRAM mirroring, CHR req/ack, deadline flag,
// ALE interactions and reset abort. A second instance covers the writable-CHR build.
module tb_ppu_bus_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic        clock_en;
   logic        ale;
   logic        rd_en;
   logic        wr_en;
   logic [1:0]  mirror_sel;
   logic [7:0]  chr_data_in;
   logic        chr_ack;
   logic [13:0] tb_drv;
   logic        tb_oe;

   wire  [13:0] bus;
   wire  [13:0] bus_w;

   logic [12:0] chr_addr,  chr_addr_w;
   logic [7:0]  chr_dout,  chr_dout_w;
   logic        rd_req,    rd_req_w;
   logic        wr_req,    wr_req_w;
   logic        busy,      busy_w;
   logic        late,      late_w;

   int n_checks = 0;
   int n_fail   = 0;

   assign bus   = tb_oe ? tb_drv : 14'bz;
   assign bus_w = tb_oe ? tb_drv : 14'bz;

   always #5 clock = ~clock;

   ppu_bus_responder #(.CHR_WRITABLE(1'b0)) dut (
      .clock(clock), .reset(reset), .clock_EN(clock_en),
      .addressData_IN_OUT(bus), .addressLatch_EN(ale),
      .read_EN(rd_en), .write_EN(wr_en), .mirror_SEL(mirror_sel),
      .chrAddress_OUT(chr_addr), .chrData_IN(chr_data_in), .chrData_OUT(chr_dout),
      .chrRead_REQ(rd_req), .chrWrite_REQ(wr_req), .chr_ACK(chr_ack),
      .busy(busy), .lateAccess_FLAG(late)
   );

   ppu_bus_responder #(.CHR_WRITABLE(1'b1)) dut_w (
      .clock(clock), .reset(reset), .clock_EN(clock_en),
      .addressData_IN_OUT(bus_w), .addressLatch_EN(ale),
      .read_EN(rd_en), .write_EN(wr_en), .mirror_SEL(mirror_sel),
      .chrAddress_OUT(chr_addr_w), .chrData_IN(chr_data_in), .chrData_OUT(chr_dout_w),
      .chrRead_REQ(rd_req_w), .chrWrite_REQ(wr_req_w), .chr_ACK(chr_ack),
      .busy(busy_w), .lateAccess_FLAG(late_w)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Momentary read strobe between edges: shows data_reg without creating a start.
   task automatic peek_bus(output logic [7:0] v);
      rd_en = 1'b1;
      #1;
      v = bus[7:0];
      rd_en = 1'b0;
      #1;
   endtask

   task automatic ale_phase(input logic [13:0] a);
      tb_oe  = 1'b1;
      tb_drv = a;
      ale    = 1'b1;
      tick();
      ale    = 1'b0;
      tb_oe  = 1'b0;
   endtask

   task automatic nt_write(input logic [13:0] a, input logic [7:0] d);
      ale_phase(a);
      tb_oe  = 1'b1;
      tb_drv = {6'h00, d};
      wr_en  = 1'b1;
      tick();
      wr_en  = 1'b0;
      tb_oe  = 1'b0;
      tick();
   endtask

   // Samples after the first edge following the start, i.e. before the deadline edge.
   task automatic nt_read(input logic [13:0] a, output logic [7:0] v);
      ale_phase(a);
      rd_en = 1'b1;
      tick();
      tick();
      v = bus[7:0];
      rd_en = 1'b0;
      tick();
   endtask

   initial begin
      logic [7:0] v;
      reset = 1'b1; clock_en = 1'b1; ale = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
      mirror_sel = 2'd0; chr_data_in = 8'h00; chr_ack = 1'b0;
      tb_drv = '0; tb_oe = 1'b0;
      repeat (3) tick();

      check("rst_busy",     busy,     1'b0);
      check("rst_rd_req",   rd_req,   1'b0);
      check("rst_wr_req",   wr_req_w, 1'b0);
      check("rst_chr_addr", chr_addr, 13'h0000);
      check("rst_chr_dout", chr_dout_w, 8'h00);
      check("rst_late",     late,     1'b0);
      reset = 1'b0;
      tick();
      peek_bus(v);
      check("rst_data_reg", v, 8'h00);

      // Known CIRAM contents at index 0x005 and 0x001
      nt_write(14'h2005, 8'h00);
      nt_write(14'h2001, 8'h4B);

      mirror_sel = 2'd1;
      nt_write(14'h2C05, 8'hA5);
      nt_read(14'h2405, v);
      check("vert_mirror", v, 8'hA5);

      mirror_sel = 2'd0;
      nt_write(14'h2C05, 8'hA5);
      nt_read(14'h2405, v);
      check("horiz_other_page", v, 8'h00);

      mirror_sel = 2'd2;
      nt_read(14'h2C05, v);
      check("single_low", v, 8'h00);
      mirror_sel = 2'd3;
      nt_read(14'h2005, v);
      check("single_high", v, 8'hA5);
      mirror_sel = 2'd0;

      // CHR read acked on its first request cycle
      ale_phase(14'h1234);
      rd_en = 1'b1;
      tick();
      check("chr_rd_req_up", rd_req, 1'b1);
      check("chr_rd_addr",   chr_addr, 13'h1234);
      chr_data_in = 8'h3C;
      chr_ack = 1'b1;
      tick();
      chr_ack = 1'b0;
      check("chr_rd_data",   bus[7:0], 8'h3C);
      check("chr_rd_req_dn", rd_req, 1'b0);
      rd_en = 1'b0;
      tick();
      check("chr_fast_late", late, 1'b0);

      nt_write(14'h2800, 8'h5A);
      nt_read(14'h2C00, v);
      check("horiz_2c00", v, 8'h5A);
      nt_read(14'h3800, v);
      check("horiz_3800", v, 8'h5A);

      // CHR read acked 6 clocks after start with clock_EN every 3rd clock
      ale_phase(14'h1234);
      rd_en = 1'b1;
      tick();
      for (int c = 1; c <= 6; c++) begin
         clock_en    = (c % 3 == 0);
         chr_ack     = (c == 6);
         chr_data_in = 8'h3C;
         tick();
         if (c == 3) check("late_before_deadline", late, 1'b0);
         if (c == 5) check("late_req_held", rd_req, 1'b1);
      end
      clock_en = 1'b1;
      chr_ack  = 1'b0;
      check("late_flag_set", late, 1'b1);
      check("late_data",     bus[7:0], 8'h3C);
      rd_en = 1'b0;
      tick();

      // CHR write to 0x0010: dropped when not writable, forwarded when writable
      ale_phase(14'h0010);
      tb_oe  = 1'b1;
      tb_drv = 14'h0077;
      wr_en  = 1'b1;
      tick();
      wr_en = 1'b0;
      tb_oe = 1'b0;
      check("ro_no_wr_req", wr_req, 1'b0);
      check("ro_idle",      busy,   1'b0);
      check("ro_dout",      chr_dout, 8'h00);
      check("rw_wr_req",    wr_req_w, 1'b1);
      check("rw_dout",      chr_dout_w, 8'h77);
      check("rw_addr",      chr_addr_w, 13'h0010);
      tick();
      check("rw_req_held",  wr_req_w, 1'b1);
      check("rw_dout_held", chr_dout_w, 8'h77);
      chr_ack = 1'b1;
      tick();
      chr_ack = 1'b0;
      check("rw_req_dn",    wr_req_w, 1'b0);
      check("rw_idle",      busy_w,   1'b0);

      // ALE and read strobe rising on the same edge
      tb_oe  = 1'b1;
      tb_drv = 14'h2001;
      ale    = 1'b1;
      rd_en  = 1'b1;
      tick();
      check("ale_defers_start", busy, 1'b0);
      ale   = 1'b0;
      tb_oe = 1'b0;
      tick();
      check("deferred_start", busy, 1'b1);
      tick();
      check("deferred_data", bus[7:0], 8'h4B);
      rd_en = 1'b0;
      tick();

      // ALE while a CHR read is in flight
      ale_phase(14'h0456);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      ale_phase(14'h1FFF);
      check("inflight_addr", chr_addr, 13'h0456);
      check("inflight_req",  rd_req,   1'b1);
      chr_data_in = 8'hE1;
      chr_ack = 1'b1;
      tick();
      chr_ack = 1'b0;
      peek_bus(v);
      check("inflight_data", v, 8'hE1);

      // Reset during the write cycle of an NT write: write is lost
      ale_phase(14'h2001);
      tb_oe  = 1'b1;
      tb_drv = 14'h00EE;
      wr_en  = 1'b1;
      tick();
      wr_en = 1'b0;
      tb_oe = 1'b0;
      reset = 1'b1;
      #1;
      check("rst_nt_wr_idle", busy, 1'b0);
      tick();
      reset = 1'b0;
      tick();

      // Reset during CHR_RD: request drops and bus released immediately
      ale_phase(14'h0100);
      rd_en = 1'b1;
      tick();
      check("abort_req_up", rd_req, 1'b1);
      reset = 1'b1;
      #1;
      check("abort_req_dn", rd_req, 1'b0);
      check("abort_late_clr", late, 1'b0);
      tb_oe  = 1'b1;
      tb_drv = 14'h0055;
      #1;
      check("abort_bus_released", bus[7:0], 8'h55);
      tb_oe = 1'b0;
      rd_en = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      nt_read(14'h2001, v);
      check("post_reset_nt_read", v, 8'h4B);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
